// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, default width and helpers for the multiply/divide unit.
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  typedef enum logic [1:0] {MD_MULTU = 2'b00, MD_MULT = 2'b01, MD_DIVU = 2'b10, MD_DIV = 2'b11} muldiv_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} muldiv_state_t;
  function automatic logic op_signed(input logic [1:0] op);
    return op[0];
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the pipeline controller and muldiv_unit.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) ();
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, flush, we_hi, we_lo, wdata, input busy, done, hi, lo);
  modport slave (input start, op, a, b, flush, we_hi, we_lo, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide on a shared adder.
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0] w_x;
  logic [WIDTH:0] w_y;
  logic [WIDTH:0] w_sum;
  // Divide subtracts via inverted operand plus carry-in; bit WIDTH of the sum is the trial sign.
  assign w_x   = i_div ? {i_hi, i_lo[WIDTH-1]} : {1'b0, i_hi};
  assign w_y   = i_div ? ~{1'b0, i_opnd} : (i_lo[0] ? {1'b0, i_opnd} : '0);
  assign w_sum = w_x + w_y + {{WIDTH{1'b0}}, i_div};
  assign o_hi  = i_div ? (w_sum[WIDTH] ? w_x[WIDTH-1:0] : w_sum[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign o_lo  = i_div ? {i_lo[WIDTH-2:0], ~w_sum[WIDTH]} : {w_sum[0], i_lo[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU owning the HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input logic     clk,
  input logic     resetn,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_FIX  = FIX;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div;
  logic               r_neg;
  logic               r_rneg;
  logic               r_dz;
  logic               w_sgn;
  logic               w_start;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic [2*WIDTH-1:0] w_prod;
  assign w_sgn   = op_signed(bus.op);
  assign w_start = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_abs_a = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_abs_b = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_prod   = r_neg ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
  // Divide by zero leaves an all-ones quotient unsigned; the remainder fix restores raw a.
  assign w_res_hi = r_div ? (r_rneg ? -r_acc_hi : r_acc_hi) : w_prod[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_div ? ((r_neg && !r_dz) ? -r_acc_lo : r_acc_lo) : w_prod[WIDTH-1:0];
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast;
  assign w_fast = w_sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b}
                        : {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`endif
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_div),
    .i_hi  (r_acc_hi),
    .i_lo  (r_acc_lo),
    .i_opnd(r_opnd),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_div    <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.we_hi) r_hi <= bus.wdata;
      if (r_state == S_IDLE && bus.we_lo) r_lo <= bus.wdata;
      if (bus.flush) r_state <= S_IDLE;
`ifdef MULDIV_FAST_MUL_EN
      else if (w_start && !bus.op[1]) begin
        r_state      <= S_DONE;
        {r_hi, r_lo} <= w_fast;
      end
`endif
      else if (w_start) begin
        r_state  <= S_RUN;
        r_cnt    <= CW'(WIDTH);
        r_div    <= bus.op[1];
        r_neg    <= w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_rneg   <= w_sgn && bus.a[WIDTH-1];
        r_dz     <= bus.b == '0;
        r_acc_hi <= '0;
        r_acc_lo <= bus.op[1] ? w_abs_a : w_abs_b;
        r_opnd   <= bus.op[1] ? w_abs_b : w_abs_a;
      end else if (r_state == S_RUN) begin
        {r_acc_hi, r_acc_lo} <= {w_step_hi, w_step_lo};
        r_cnt                <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) r_state <= S_FIX;
      end else if (r_state == S_FIX) begin
        r_state <= S_DONE;
        r_hi    <= w_res_hi;
        r_lo    <= w_res_lo;
      end else if (r_state == S_DONE) r_state <= S_IDLE;
    end
  end
  assign bus.busy = r_state != S_IDLE;
  assign bus.done = r_state == S_DONE;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a queued scoreboard checked by an independent done monitor.
`timescale 1ns/1ps
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int W   = 32;
  localparam int LAT = W + 3;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit         FAST  = 1'b1;
  localparam muldiv_op_t FL_OP = MD_DIVU;
`else
  localparam bit         FAST  = 1'b0;
  localparam muldiv_op_t FL_OP = MD_MULTU;
`endif
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
    string        name;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;
  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every done pulse must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (resetn && bus.done) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_done: cyc=%0d hi=%h lo=%h, required no done", cyc, bus.hi, bus.lo);
      end else begin
        e = sb.pop_front();
        if (bus.hi !== e.hi || bus.lo !== e.lo || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s: got hi=%h lo=%h cyc=%0d, required hi=%h lo=%h cyc=%0d",
                   e.name, bus.hi, bus.lo, cyc, e.hi, e.lo, e.cyc);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required self-termination");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask
  function automatic int lat(input muldiv_op_t op);
    return (op[1] || !FAST) ? LAT : 2;
  endfunction
  task automatic launch(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input string nm, input bit exp_done);
    exp_t x;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    x = '{hi, lo, cyc + lat(op) - 1, nm};
    if (exp_done) sb.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic finish_op(input string nm);
    for (int i = 0; i < 4 * W && bus.busy; i++) @(negedge clk);
    chk({nm, "_busy_low"}, W'(bus.busy), '0);
    @(negedge clk);
  endtask
  task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input string nm);
    launch(op, a, b, hi, lo, nm, 1'b1);
    finish_op(nm);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op    = MD_MULTU;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    resetn = 1'b1;
    @(negedge clk);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    issue(MD_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
    issue(MD_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, "mult_both_neg");
    issue(MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift");
    issue(MD_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, "mult_6x7");
    issue(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    issue(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negb");
    issue(MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu_zero");
    issue(MD_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, "div_sneg_zero");
    issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
    issue(MD_DIVU,  32'h00000007, 32'h00000009, 32'h00000007, 32'h00000000, "divu_small");
    bus.we_hi = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b1;
    bus.wdata = 32'h5678;
    @(negedge clk);
    bus.we_lo = 1'b0;
    chk("mthi", bus.hi, 32'h1234);
    chk("mtlo", bus.lo, 32'h5678);
    // Abort in cycle 10 of the operation (start cycle counted as 1).
    launch(FL_OP, 32'd3, 32'd5, '0, '0, "flush_mid", 1'b0);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", W'(bus.busy), '0);
    chk("flush_hi", bus.hi, 32'h1234);
    chk("flush_lo", bus.lo, 32'h5678);
    repeat (W + 5) @(negedge clk);
    launch(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_ign_start", 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_MULTU;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op("divu_ign_start");
    bus.we_hi = 1'b1;
    bus.wdata = 32'hAAAA;
    launch(MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "mthi_with_start", 1'b1);
    bus.we_hi = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
    chk("mthi_lands", bus.hi, 32'hAAAA);
    bus.we_lo = 1'b1;
    bus.wdata = 32'hBBBB;
    @(negedge clk);
    bus.we_lo = 1'b0;
    chk("mtlo_busy_ignored", bus.lo, 32'd14);
`endif
    finish_op("mthi_with_start");
    // Flush while in FIX must drop the result.
    launch(MD_DIVU, 32'd50, 32'd3, '0, '0, "fix_flush", 1'b0);
    repeat (W) @(negedge clk);
    chk("fix_busy", W'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fix_flush_busy", W'(bus.busy), '0);
    chk("fix_flush_hi", bus.hi, 32'd0);
    chk("fix_flush_lo", bus.lo, 32'd6);
    repeat (8) @(negedge clk);
    launch(MD_DIV, 32'hFFFFFFF9, 32'd2, '0, '0, "rst_mid", 1'b0);
    repeat (18) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_mid_busy", W'(bus.busy), '0);
    chk("rst_mid_hi", bus.hi, '0);
    chk("rst_mid_lo", bus.lo, '0);
    repeat (W + 5) @(negedge clk);
    issue(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "mult_6x7_after_rst");
    chk("sb_drained", W'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
